tile_draw_datapath: RTL and testbench
=====================================

// Module: tile_draw_datapath
// PURPOSE
//  Datapath downstream of the graphics control FSM. Latches which tile (0-3) and which colour
//  (base or flash) to draw, then, on start, raster-scans that tile's rectangle on the 160x120 VGA grid.
//  It emits one pixel per cycle (x, y, colour, plot) straight into the VGA adapter.
//  When the rectangle is finished it reports done so the FSM can return to tile_select.
// PARAMETERS
//  TILE_W  80  tile width in pixels (screen width = 2*TILE_W)
//  TILE_H  60  tile height in pixels (screen height = 2*TILE_H)
//  X_W     8   width of x coordinate
//  Y_W     7   width of y coordinate
// PORTS
//  clock     in   1    system clock; all state changes on the rising edge
//  resetn    in   1    asynchronous, active-low reset
//  ld_t0     in   1    select tile 0 (top-left)
//  ld_t1     in   1    select tile 1 (top-right)
//  ld_t2     in   1    select tile 2 (bottom-left)
//  ld_t3     in   1    select tile 3 (bottom-right)
//  ld_flash  in   1    next draw uses the flash colour
//  start     in   1    begin drawing the selected tile (the FSM draw-state strobe)
//  x         out  X_W  pixel x to VGA adapter
//  y         out  Y_W  pixel y to VGA adapter
//  colour    out  3    RGB pixel colour
//  plot      out  1    VGA write enable; high exactly while x/y/colour are a valid pixel
//  busy      out  1    high from the cycle after start is accepted until done
//  done      out  1    one-cycle pulse after the last pixel
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - Go to IDLE immediately, even mid-draw; the remaining pixels are not drawn.
//   - tile=0, flash=0, counters=0; x=y=colour=plot=busy=done=0 while in reset.
//  Tile register:
//   - On an edge where a ld_tN is high and the state is IDLE, load the tile index.
//   - Several ld_tN high at once: the lowest index wins.
//   - ld_* are ignored in DRAW and DONE.
//  Flash flag:
//   - Set by ld_flash in IDLE.
//   - Cleared on the DONE cycle, so each flash draw is one-shot.
//  FSM (states IDLE -> DRAW -> DONE -> IDLE):
//   - IDLE: plot=0, busy=0. start=1 goes to DRAW with cx=cy=0.
//   - DRAW: plot=1, busy=1.
//     - cx increments each cycle. At cx==TILE_W-1, cx wraps to 0 and cy increments.
//     - At cx==TILE_W-1 and cy==TILE_H-1, go to DONE.
//   - DONE: plot=0, busy=1, done=1 for one cycle, then IDLE.
//  start is ignored outside IDLE; there is no queueing.
//  Same-edge start and ld_*:
//   - Loads and start on the same IDLE edge both take effect on that edge.
//   - The draw uses the newly loaded tile and flash values.
//  Coordinates:
//   - x = ox+cx and y = oy+cy, combinational from the registers.
//   - Origins: t0=(0,0), t1=(TILE_W,0), t2=(0,TILE_H), t3=(TILE_W,TILE_H).
//   - Sums must never overflow X_W/Y_W with the default parameters (max x=159, y=119).
//  Colour:
//   - flash=1 gives 3'b111.
//   - Otherwise: t0=3'b100 red, t1=3'b010 green, t2=3'b001 blue, t3=3'b110 yellow.
//  Latency:
//   - start is sampled at edge E; the first pixel is valid after E.
//   - TILE_W*TILE_H plot cycles follow; done is high on cycle TILE_W*TILE_H+1 after E.
// STRUCTURE
//  Shared package graphics_pkg holds:
//   - TILE_W and TILE_H defaults
//   - colour constants COL_RED, COL_GREEN, COL_BLUE, COL_YELLOW, COL_FLASH
//   - tile origin table
//   - state encodings for IDLE, DRAW, DONE
//  One sub-module, pixel_scan_counter:
//   - 2-D cx/cy counter with clear, enable and a last flag; parameterised by W and H.
//  This top holds the FSM, the tile and flash registers, the origin adder and the colour mux.
// TESTING
//  1. Reset, then ld_t0 and start together -> 4800 plot cycles covering x 0..79, y 0..59, colour 100; done once at cycle 4801.
//  2. ld_t3 with ld_flash, then start -> x 80..159, y 60..119, colour 111; a following start with no ld_flash draws colour 110.
//  3. ld_t1 and ld_t2 together -> tile 1 is chosen; first pixel (80,0), last pixel (159,59), colour 010.
//  4. start pulse and ld_t2 mid-draw -> both ignored; draw finishes unchanged; no second draw; tile stays as before.
//  5. resetn low at pixel 1000 -> plot, busy and done go 0 at once; after release, IDLE with tile=0 and flash=0.
//  6. Small parameters (W=4, H=2) -> exactly 8 plots in row-major order; raster wrap checked at cx=3.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared constants and types for the tile graphics path: tile geometry defaults,
// colour codes, the tile origin table and the draw FSM encoding.
package graphics_pkg;

    localparam int TILE_W_DEFAULT = 80;
    localparam int TILE_H_DEFAULT = 60;

    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_FLASH  = 3'b111;

    // Origin table indexed by tile: bit set means offset by one tile width/height.
    localparam logic [3:0] ORIGIN_COL = 4'b1010;
    localparam logic [3:0] ORIGIN_ROW = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

    function automatic logic [2:0] tile_colour(input logic [1:0] tile, input logic flash);
        logic [2:0] col;
        case (tile)
            2'd0:    col = COL_RED;
            2'd1:    col = COL_GREEN;
            2'd2:    col = COL_BLUE;
            default: col = COL_YELLOW;
        endcase
        return flash ? COL_FLASH : col;
    endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Row-major 2-D raster counter over a W x H rectangle with synchronous clear,
// count enable and a flag marking the final (W-1, H-1) position.
module pixel_scan_counter #(
    parameter int W  = 80,
    parameter int H  = 60,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          enable,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last
);

    localparam logic [XW-1:0] CX_LAST = XW'(W - 1);
    localparam logic [YW-1:0] CY_LAST = YW'(H - 1);

    assign last = (cx == CX_LAST) && (cy == CY_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (cx == CX_LAST) begin
                cx <= '0;
                cy <= (cy == CY_LAST) ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_draw_datapath.sv
// Draws one quarter-screen tile: latches tile/flash selection, raster-scans the
// tile rectangle one pixel per cycle into the VGA adapter and pulses done at the end.
module tile_draw_datapath
    import graphics_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEFAULT,
    parameter int TILE_H = TILE_H_DEFAULT,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           ld_t0,
    input  logic           ld_t1,
    input  logic           ld_t2,
    input  logic           ld_t3,
    input  logic           ld_flash,
    input  logic           start,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done,
    output logic [1:0]     fsm_state
);

    // plot is a valid strobe with no ready: the adapter takes every offered pixel,
    // and x/y/colour are only meaningful in cycles where plot is high.
    draw_state_t    state;
    logic [1:0]     tile;
    logic           flash;
    logic           any_ld;
    logic [1:0]     ld_idx;
    logic           scan_clear;
    logic           scan_en;
    logic           scan_last;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [X_W-1:0] ox;
    logic [Y_W-1:0] oy;

    always_comb begin
        any_ld = ld_t0 | ld_t1 | ld_t2 | ld_t3;
        if (ld_t0)      ld_idx = 2'd0;
        else if (ld_t1) ld_idx = 2'd1;
        else if (ld_t2) ld_idx = 2'd2;
        else            ld_idx = 2'd3;
    end

    assign scan_clear = (state == ST_IDLE);
    assign scan_en    = (state == ST_DRAW);

    pixel_scan_counter #(
        .W (TILE_W),
        .H (TILE_H),
        .XW(X_W),
        .YW(Y_W)
    ) u_scan (
        .clock (clock),
        .resetn(resetn),
        .clear (scan_clear),
        .enable(scan_en),
        .cx    (cx),
        .cy    (cy),
        .last  (scan_last)
    );

    assign ox        = ORIGIN_COL[tile] ? X_W'(TILE_W) : '0;
    assign oy        = ORIGIN_ROW[tile] ? Y_W'(TILE_H) : '0;
    assign x         = ox + cx;
    assign y         = oy + cy;
    assign colour    = plot ? tile_colour(tile, flash) : 3'b000;
    assign fsm_state = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            tile  <= 2'd0;
            flash <= 1'b0;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_ld)   tile  <= ld_idx;
                    if (ld_flash) flash <= 1'b1;
                    if (start) begin
                        state <= ST_DRAW;
                        plot  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (scan_last) begin
                        state <= ST_DONE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    flash <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_draw_datapath.sv
// Bench for tile_draw_datapath: default-size instance plus a 4x2 instance,
// with an expected-pixel queue filled at stimulus time and drained on plot.
module tb_tile_draw_datapath;

    localparam int W  = 80;
    localparam int H  = 60;
    localparam int N  = W * H;
    localparam int SW = 4;
    localparam int SH = 2;
    localparam int SN = SW * SH;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ld_t0, ld_t1, ld_t2, ld_t3, ld_flash, start;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;
    logic [1:0] fsm_state;

    logic       s_ld_t3, s_start;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] s_colour;
    logic       s_plot, s_busy, s_done;
    logic [1:0] s_fsm_state;

    logic [17:0] exp_q[$];
    logic [17:0] got;
    logic [17:0] exp_w;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    tile_draw_datapath dut (
        .clock(clock), .resetn(resetn),
        .ld_t0(ld_t0), .ld_t1(ld_t1), .ld_t2(ld_t2), .ld_t3(ld_t3),
        .ld_flash(ld_flash), .start(start),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
        .fsm_state(fsm_state)
    );

    tile_draw_datapath #(.TILE_W(SW), .TILE_H(SH)) dut_small (
        .clock(clock), .resetn(resetn),
        .ld_t0(1'b0), .ld_t1(1'b0), .ld_t2(1'b0), .ld_t3(s_ld_t3),
        .ld_flash(1'b0), .start(s_start),
        .x(sx), .y(sy), .colour(s_colour), .plot(s_plot), .busy(s_busy), .done(s_done),
        .fsm_state(s_fsm_state)
    );

    task automatic idle_inputs();
        ld_t0 = 0; ld_t1 = 0; ld_t2 = 0; ld_t3 = 0; ld_flash = 0; start = 0;
        s_ld_t3 = 0; s_start = 0;
    endtask

    // Reference raster: tile t origin is ((t%2)*w, (t/2)*h), row-major scan.
    task automatic push_tile(input int t, input logic [2:0] col, input int w, input int h);
        for (int cy = 0; cy < h; cy++)
            for (int cx = 0; cx < w; cx++)
                exp_q.push_back({8'((t % 2) * w + cx), 7'((t / 2) * h + cy), col});
    endtask

    task automatic test_reset();
        resetn = 0;
        idle_inputs();
        repeat (3) @(negedge clock);
        n_checks++;
        if ({x, y, colour, plot, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {x, y, colour, plot, busy, done});
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", fsm_state);
        end
        resetn = 1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({plot, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b required 000", {plot, busy, done});
        end
    endtask

    task automatic test_tile0_same_edge();
        int done_at;
        done_at = 0;
        ld_t0 = 1; start = 1;
        push_tile(0, 3'b100, W, H);
        for (int cyc = 1; cyc <= N + 5; cyc++) begin
            @(negedge clock);
            if (cyc == 1) idle_inputs();
            if (plot) begin
                got = {x, y, colour};
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                n_checks++;
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL t0_pixel: cycle %0d got %h required %h", cyc, got, exp_w);
                end
            end
            if (done) begin
                done_at = cyc;
                break;
            end
        end
        n_checks++;
        if (done_at !== N + 1) begin
            n_fail++;
            $display("FAIL t0_done_cycle: got %0d required %0d", done_at, N + 1);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL t0_pixels_missing: got %0d left required 0", exp_q.size());
        end
        exp_q.delete();
        @(negedge clock);
        n_checks++;
        if ({done, busy, fsm_state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL t0_after_done: got %b required 0000", {done, busy, fsm_state});
        end
    endtask

    task automatic test_flash_one_shot();
        int done_at;
        ld_t3 = 1; ld_flash = 1;
        @(negedge clock);
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            done_at = 0;
            start = 1;
            push_tile(3, (d == 0) ? 3'b111 : 3'b110, W, H);
            for (int cyc = 1; cyc <= N + 5; cyc++) begin
                @(negedge clock);
                if (cyc == 1) idle_inputs();
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flash_busy: draw %0d cycle %0d got %b required 1", d, cyc, busy);
                end
                if (plot) begin
                    got = {x, y, colour};
                    exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                    n_checks++;
                    if (got !== exp_w) begin
                        n_fail++;
                        $display("FAIL flash_pixel: draw %0d cycle %0d got %h required %h", d, cyc, got, exp_w);
                    end
                end
                if (done) begin
                    done_at = cyc;
                    break;
                end
            end
            n_checks++;
            if (done_at !== N + 1 || exp_q.size() !== 0) begin
                n_fail++;
                $display("FAIL flash_done: draw %0d got done at %0d with %0d left required %0d with 0",
                         d, done_at, exp_q.size(), N + 1);
            end
            exp_q.delete();
            @(negedge clock);
        end
    endtask

    task automatic test_priority();
        int done_at;
        int plots;
        done_at = 0;
        plots = 0;
        ld_t1 = 1; ld_t2 = 1; start = 1;
        push_tile(1, 3'b010, W, H);
        for (int cyc = 1; cyc <= N + 5; cyc++) begin
            @(negedge clock);
            if (cyc == 1) idle_inputs();
            if (plot) begin
                got = {x, y, colour};
                if (plots == 0) begin
                    n_checks++;
                    if ({x, y} !== {8'd80, 7'd0}) begin
                        n_fail++;
                        $display("FAIL prio_first_pixel: got (%0d,%0d) required (80,0)", x, y);
                    end
                end
                if (plots == N - 1) begin
                    n_checks++;
                    if ({x, y} !== {8'd159, 7'd59}) begin
                        n_fail++;
                        $display("FAIL prio_last_pixel: got (%0d,%0d) required (159,59)", x, y);
                    end
                end
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                n_checks++;
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL prio_pixel: cycle %0d got %h required %h", cyc, got, exp_w);
                end
                plots++;
            end
            if (done) begin
                done_at = cyc;
                break;
            end
        end
        n_checks++;
        if (done_at !== N + 1 || plots !== N) begin
            n_fail++;
            $display("FAIL prio_done: got done %0d plots %0d required %0d and %0d", done_at, plots, N + 1, N);
        end
        exp_q.delete();
        @(negedge clock);
    endtask

    task automatic test_mid_draw_ignored();
        int done_at;
        int stray;
        for (int d = 0; d < 2; d++) begin
            done_at = 0;
            start = 1;
            push_tile(1, 3'b010, W, H);
            for (int cyc = 1; cyc <= N + 5; cyc++) begin
                @(negedge clock);
                if (cyc == 1) idle_inputs();
                if (plot) begin
                    got = {x, y, colour};
                    exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                    n_checks++;
                    if (got !== exp_w) begin
                        n_fail++;
                        $display("FAIL mid_pixel: draw %0d cycle %0d got %h required %h", d, cyc, got, exp_w);
                    end
                end
                if (done) begin
                    done_at = cyc;
                    break;
                end
                if (d == 0 && cyc == 100) begin
                    start = 1; ld_t2 = 1; ld_flash = 1;
                end
                if (cyc == 101) idle_inputs();
            end
            n_checks++;
            if (done_at !== N + 1 || exp_q.size() !== 0) begin
                n_fail++;
                $display("FAIL mid_done: draw %0d got done at %0d with %0d left required %0d with 0",
                         d, done_at, exp_q.size(), N + 1);
            end
            exp_q.delete();
            stray = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (plot || busy) stray++;
            end
            n_checks++;
            if (stray !== 0) begin
                n_fail++;
                $display("FAIL mid_no_second_draw: got %0d busy cycles required 0", stray);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        int done_at;
        ld_t3 = 1; ld_flash = 1;
        @(negedge clock);
        idle_inputs();
        start = 1;
        push_tile(3, 3'b111, W, H);
        for (int cyc = 1; cyc <= N + 5; cyc++) begin
            @(negedge clock);
            if (cyc == 1) idle_inputs();
            if (cyc == 1001) begin
                resetn = 0;
                #1;
                n_checks++;
                if ({plot, busy, done, fsm_state} !== 5'b00000) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs: got %b required 00000", {plot, busy, done, fsm_state});
                end
                break;
            end
            if (plot) begin
                got = {x, y, colour};
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                n_checks++;
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL rst_pre_pixel: cycle %0d got %h required %h", cyc, got, exp_w);
                end
            end
        end
        exp_q.delete();
        @(negedge clock);
        resetn = 1;
        @(negedge clock);
        done_at = 0;
        start = 1;
        push_tile(0, 3'b100, W, H);
        for (int cyc = 1; cyc <= N + 5; cyc++) begin
            @(negedge clock);
            if (cyc == 1) idle_inputs();
            if (plot) begin
                got = {x, y, colour};
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                n_checks++;
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL rst_post_pixel: cycle %0d got %h required %h", cyc, got, exp_w);
                end
            end
            if (done) begin
                done_at = cyc;
                break;
            end
        end
        n_checks++;
        if (done_at !== N + 1 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rst_post_done: got done at %0d with %0d left required %0d with 0",
                     done_at, exp_q.size(), N + 1);
        end
        exp_q.delete();
        @(negedge clock);
    endtask

    task automatic test_small_raster();
        int done_at;
        int plots;
        done_at = 0;
        plots = 0;
        s_ld_t3 = 1; s_start = 1;
        push_tile(3, 3'b110, SW, SH);
        for (int cyc = 1; cyc <= SN + 5; cyc++) begin
            @(negedge clock);
            if (cyc == 1) idle_inputs();
            if (s_plot) begin
                got = {sx, sy, s_colour};
                if (plots == 4) begin
                    n_checks++;
                    if ({sx, sy} !== {8'd4, 7'd3}) begin
                        n_fail++;
                        $display("FAIL small_wrap: got (%0d,%0d) required (4,3)", sx, sy);
                    end
                end
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                n_checks++;
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL small_pixel: cycle %0d got %h required %h", cyc, got, exp_w);
                end
                plots++;
            end
            if (s_done) begin
                done_at = cyc;
                break;
            end
        end
        n_checks++;
        if (done_at !== SN + 1 || plots !== SN) begin
            n_fail++;
            $display("FAIL small_done: got done %0d plots %0d required %0d and %0d", done_at, plots, SN + 1, SN);
        end
        exp_q.delete();
        @(negedge clock);
        n_checks++;
        if ({s_busy, s_done, s_fsm_state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL small_idle: got %b required 0000", {s_busy, s_done, s_fsm_state});
        end
    endtask

    initial begin
        test_reset();
        test_tile0_same_edge();
        test_flash_one_shot();
        test_priority();
        test_mid_draw_ignored();
        test_reset_mid_draw();
        test_small_raster();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
